// File: rtl/muldiv_unit.sv
// Iterative multiply / divide / modulo execute unit: shift-add MUL, restoring DIV/MOD on magnitudes.
// Optional MUL early exit when the remaining multiplier bits are zero: define MULDIV_EARLY_EXIT_EN.
module muldiv_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_MUL = 4'b1000,
    parameter logic [3:0] ALU_DIV = 4'b1001,
    parameter logic [3:0] ALU_MOD = 4'b1010
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_aluctl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_res,
    output logic             o_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic             is_mul_q, is_mod_q, neg_quo_q, neg_rem_q;
    // acc: product or partial remainder; sh: multiplier or dividend/quotient; op: multiplicand or divisor
    logic [WIDTH-1:0] acc_q, sh_q, op_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;

    logic             op_valid, accept, b_zero, zero_exit, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] acc_d, sh_d, op_d, final_res;

    always_comb begin
        op_valid = (i_aluctl == ALU_MUL) || (i_aluctl == ALU_DIV) || (i_aluctl == ALU_MOD);
        accept   = (state_q == IDLE) && i_start && op_valid;
        b_zero   = (i_b == '0);
`ifdef MULDIV_EARLY_EXIT_EN
        zero_exit = b_zero;
`else
        zero_exit = b_zero && (i_aluctl != ALU_MUL);
`endif
        a_mag = i_a[WIDTH-1] ? ('0 - i_a) : i_a;
        b_mag = i_b[WIDTH-1] ? ('0 - i_b) : i_b;

        shifted = {acc_q, sh_q[WIDTH-1]};
        diff    = shifted - {1'b0, op_q};

        if (is_mul_q) begin
            acc_d = acc_q + (sh_q[0] ? op_q : '0);
            sh_d  = sh_q >> 1;
            op_d  = op_q << 1;
        end else begin
            op_d = op_q;
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end

        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_EXIT_EN
        if (is_mul_q && (sh_d == '0)) begin
            last_iter = 1'b1;
        end
`endif

        if (is_mul_q) begin
            final_res = acc_d;
        end else if (is_mod_q) begin
            final_res = neg_rem_q ? ('0 - acc_d) : acc_d;
        end else begin
            final_res = neg_quo_q ? ('0 - sh_d) : sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = zero_exit ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            is_mul_q  <= 1'b0;
            is_mod_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            sh_q      <= '0;
            op_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        is_mul_q  <= (i_aluctl == ALU_MUL);
                        is_mod_q  <= (i_aluctl == ALU_MOD);
                        neg_quo_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                        neg_rem_q <= i_a[WIDTH-1];
                        acc_q     <= '0;
                        err_q     <= 1'b0;
                        if (i_aluctl == ALU_MUL) begin
                            sh_q <= i_b;
                            op_q <= i_a;
                        end else begin
                            sh_q <= a_mag;
                            op_q <= b_mag;
                        end
                        // Zero operand short-circuits straight into DONE, so the result lands now
                        if (zero_exit) begin
                            if (i_aluctl == ALU_MUL) begin
                                res_q <= '0;
                            end else begin
                                res_q <= (i_aluctl == ALU_MOD) ? i_a : '1;
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    op_q  <= op_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        res_q <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);
    assign o_res  = res_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32) with hand-computed results and latencies.
module tb_muldiv_unit;

    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_DIV = 4'b1001;
    localparam logic [3:0] C_MOD = 4'b1010;
    localparam logic [3:0] C_ADD = 4'b0010;

`ifdef MULDIV_EARLY_EXIT_EN
    localparam int LAT_MUL_6X7 = 4;
`else
    localparam int LAT_MUL_6X7 = 33;
`endif

    logic        clk = 1'b0;
    logic        i_rst, i_start;
    logic [3:0]  i_aluctl;
    logic [31:0] i_a, i_b;
    logic        o_busy, o_done, o_err;
    logic [31:0] o_res;

    int n_total = 0;
    int n_bad   = 0;

    muldiv_unit #(
        .WIDTH   (32),
        .ALU_MUL (C_MUL),
        .ALU_DIV (C_DIV),
        .ALU_MOD (C_MOD)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_aluctl (i_aluctl),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_res    (o_res),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; optionally fire a second (MUL) start on RUN cycle inject_cyc.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_err, input int inject_cyc);
        int lat;
        bit busy_ok;
        @(negedge clk);
        i_start  = 1'b1;
        i_aluctl = code;
        i_a      = a;
        i_b      = b;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (!o_busy) busy_ok = 1'b0;
            if (o_done) lat = c;
            if (c == inject_cyc) begin
                i_start  = 1'b1;
                i_aluctl = C_MUL;
                i_a      = 32'd3;
                i_b      = 32'd3;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".res"}, o_res, exp_res);
        check_val({tag, ".err"}, {31'd0, o_err}, {31'd0, exp_err});
        check_val({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        check_val({tag, ".idle"}, {30'd0, o_busy, o_done}, 32'd0);
    endtask

    initial begin
        bit seen;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_aluctl = 4'd0;
        i_a      = '0;
        i_b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        check_val("rst.busy", {31'd0, o_busy}, 32'd0);
        check_val("rst.done", {31'd0, o_done}, 32'd0);
        check_val("rst.res",  o_res, 32'd0);
        check_val("rst.err",  {31'd0, o_err}, 32'd0);

        run_op("mul_7_m3",   C_MUL, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB, 1'b0, 0);
        run_op("div_m7_2",   C_DIV, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 1'b0, 0);
        run_op("mod_m7_2",   C_MOD, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 1'b0, 0);
        run_op("div_7_m3",   C_DIV, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFFE, 1'b0, 0);
        run_op("mod_7_m3",   C_MOD, 32'd7,        32'hFFFFFFFD, 33, 32'd1,        1'b0, 0);
        run_op("div_m7_m2",  C_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 32'd3,        1'b0, 0);
        run_op("div_min_m1", C_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 1'b0, 0);
        run_op("mod_min_m1", C_MOD, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0,        1'b0, 0);
        run_op("div_9_0",    C_DIV, 32'd9,        32'd0,        1,  32'hFFFFFFFF, 1'b1, 0);
        run_op("mod_9_0",    C_MOD, 32'd9,        32'd0,        1,  32'd9,        1'b1, 0);

        // Non-long-latency code must be ignored and leave the held result alone
        @(negedge clk);
        i_start  = 1'b1;
        i_aluctl = C_ADD;
        i_a      = 32'd1;
        i_b      = 32'd2;
        seen     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy || o_done) seen = 1'b1;
        end
        check_val("add.ignored", {31'd0, seen}, 32'd0);
        check_val("add.res_hold", o_res, 32'd9);
        check_val("add.err_hold", {31'd0, o_err}, 32'd1);

        run_op("div_100_7_inj", C_DIV, 32'd100, 32'd7, 33, 32'd14, 1'b0, 5);

        // Reset on cycle 10 of a DIV aborts it with no done pulse
        @(negedge clk);
        i_start  = 1'b1;
        i_aluctl = C_DIV;
        i_a      = 32'd1000;
        i_b      = 32'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("abort.busy_pre", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_val("abort.busy", {31'd0, o_busy}, 32'd0);
        check_val("abort.res",  o_res, 32'd0);
        check_val("abort.err",  {31'd0, o_err}, 32'd0);
        seen = o_done;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done || o_busy) seen = 1'b1;
        end
        check_val("abort.no_done", {31'd0, seen}, 32'd0);

        run_op("mul_6_7", C_MUL, 32'd6, 32'd7, LAT_MUL_6X7, 32'd42, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle execute unit; sits directly downstream of alu_ctrl.
- Consumes the 4-bit ALU control code plus two operands; handles the long-latency codes `ALU_MUL`, `ALU_DIV` and `ALU_MOD` (from defs.v).
- Single-cycle codes stay in the combinational ALU.
- The pipeline stalls on o_busy and captures o_res when o_done pulses.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request strobe; sampled only in IDLE.
- i_aluctl  input  4  ALU control code from alu_ctrl (o_aluctl).
- i_a  input  WIDTH  operand A / dividend, two's complement.
- i_b  input  WIDTH  operand B / divisor, two's complement.
- o_busy  output  1  high whenever state != IDLE.
- o_done  output  1  one-cycle pulse; o_res/o_err valid in that cycle.
- o_res  output  WIDTH  result register; holds until the next accepted request completes or reset.
- o_err  output  1  divide-by-zero flag; valid with o_done, held with o_res.

Behaviour:
- Reset (i_rst=1 at edge): state=IDLE; o_busy=0, o_done=0, o_res=0, o_err=0.
  - Reset aborts any in-flight operation; no o_done is produced for it.
- Accept: in IDLE, i_start=1 and i_aluctl in {`ALU_MUL`, `ALU_DIV`, `ALU_MOD`}.
  - At the accept edge, latch the op and operands; clear o_err; counter=0.
  - i_start with any other code is ignored; the unit stays IDLE.
  - i_start in RUN or DONE is ignored; there is no queueing.
- States:
  - IDLE -> RUN on accept.
  - IDLE -> DONE on accept when op is DIV or MOD and i_b==0.
  - RUN -> DONE after WIDTH iterations (counter reaches WIDTH-1).
  - DONE -> IDLE unconditionally after one cycle; o_done=1 only in DONE.
- Latency, counted from the accept edge:
  - Normal operation: o_done high in cycle WIDTH+1; IDLE again in cycle WIDTH+2.
  - Divide-by-zero: o_done high in cycle 1.
- o_busy = (state != IDLE), registered-state decode; high from cycle 1 through the DONE cycle.
- MUL:
  - Shift-add, one multiplier bit per RUN cycle, LSB first.
  - o_res = low WIDTH bits of i_a*i_b; identical for signed and unsigned operands.
  - Overflow is silently truncated; o_err=0.
- DIV/MOD:
  - Restoring division on magnitudes |A|, |B| (WIDTH-bit unsigned), one quotient bit per RUN cycle, MSB first.
  - Signs are applied in the DONE transition.
  - Quotient truncates toward zero; it is negated if the signs of A and B differ.
  - Remainder takes the sign of A: it is negated if A<0.
  - DIV writes the quotient to o_res; MOD writes the remainder.
- Boundaries:
  - Most-negative / -1: |MIN| is 2^(WIDTH-1) unsigned, so the quotient wraps to MIN and the remainder is 0; o_err=0.
  - Divide-by-zero: DIV gives o_res=all ones; MOD gives o_res=i_a; o_err=1.
  - Operand inputs are don't-care after the accept edge.
- o_res and o_err are written only in the cycle entering DONE; otherwise they hold.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: MUL checks the remaining (not yet consumed) multiplier bits.
  - If the remaining bits are zero after a RUN iteration, go to DONE next cycle.
  - If i_b==0 at accept, go IDLE -> DONE directly (o_done in cycle 1, o_res=0).
  - Example: i_b=5 -> o_done in cycle 4.
  - DIV/MOD latency is unchanged.
- Undefined: MUL always takes WIDTH RUN cycles; no early-exit logic is synthesized.

Test Plan:
- MUL: A=7, B=-3 (0xFFFFFFFD) -> o_done exactly 33 cycles after accept, o_res=0xFFFFFFEB, o_err=0, o_busy high cycles 1..33.
- DIV A=-7, B=2 -> o_res=0xFFFFFFFD (-3); MOD with the same operands -> o_res=0xFFFFFFFF (-1); both with o_done at cycle 33.
- DIV A=0x80000000, B=0xFFFFFFFF -> o_res=0x80000000, o_err=0; MOD with the same operands -> o_res=0.
- DIV A=9, B=0 -> o_done at cycle 1, o_res=0xFFFFFFFF, o_err=1; MOD A=9, B=0 -> o_res=9, o_err=1.
- i_start with i_aluctl=`ALU_ADD` -> o_busy stays 0, no o_done. A second i_start during RUN is ignored; the first result is unaffected.
- Assert i_rst at cycle 10 of a DIV -> next cycle o_busy=0, o_res=0, o_err=0, no o_done. A fresh MUL 6*7 afterwards -> o_res=42.
